// File: rtl/find_bw_left_edge.sv
// Left bandwidth edge finder: locate the spectrum peak, then walk toward bin 0
// until power drops THRESHOLD_DB below the peak, reporting the bracketing bins.
module find_bw_left_edge #(
    parameter int ACCUM_WIDTH    = 18,
    parameter int FREQ_BIN_WIDTH = 16,
    parameter int THRESHOLD_DB   = 7680,
    parameter int NUM_ACCUMS     = 24
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic signed [ACCUM_WIDTH-1:0]    accumulator_val_i [NUM_ACCUMS],
    input  logic signed [FREQ_BIN_WIDTH-1:0] freq_bin_i        [NUM_ACCUMS],
    output logic signed [FREQ_BIN_WIDTH-1:0] f1_o,
    output logic signed [FREQ_BIN_WIDTH-1:0] f2_o,
    output logic signed [ACCUM_WIDTH-1:0]    L1_o,
    output logic signed [ACCUM_WIDTH-1:0]    L2_o,
    output logic                             valid_o,
    output logic                             busy_o
);

    localparam int IdxW = (NUM_ACCUMS > 1) ? $clog2(NUM_ACCUMS) : 1;
    localparam int ExtW = ACCUM_WIDTH + 1;
    localparam logic [IdxW-1:0]        LastIdx = IdxW'(NUM_ACCUMS - 1);
    localparam logic signed [ExtW-1:0] ThrExt  = ExtW'(THRESHOLD_DB);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StFindPeak = 2'd1;
    localparam logic [1:0] StSearch   = 2'd2;
    localparam logic [1:0] StDone     = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic [IdxW-1:0]                 peak_idx_q, peak_idx_d;
    logic signed [ACCUM_WIDTH-1:0]   peak_val_q, peak_val_d;
    logic signed [ExtW-1:0]          target_q, target_d;
    logic signed [FREQ_BIN_WIDTH-1:0] f1_q, f1_d, f2_q, f2_d;
    logic signed [ACCUM_WIDTH-1:0]   l1_q, l1_d, l2_q, l2_d;

    logic signed [ACCUM_WIDTH-1:0]   cur_val;
    logic [IdxW-1:0]                 idx_up;
    logic                            new_peak;
    logic signed [ACCUM_WIDTH-1:0]   fin_peak_val;
    logic [IdxW-1:0]                 fin_peak_idx;
    logic signed [ExtW-1:0]          fin_target;
    logic signed [ExtW-1:0]          cur_ext;
    logic                            hit;

    always_comb begin
        cur_val = accumulator_val_i[idx_q];
        idx_up  = idx_q + 1'b1;
        // Strict compare so equal maxima keep the lowest index.
        new_peak     = (idx_q == '0) || (cur_val > peak_val_q);
        fin_peak_val = new_peak ? cur_val : peak_val_q;
        fin_peak_idx = new_peak ? idx_q : peak_idx_q;
        // One extra bit keeps the subtraction from wrapping near the negative limit.
        fin_target = $signed({fin_peak_val[ACCUM_WIDTH-1], fin_peak_val}) - ThrExt;
        cur_ext    = $signed({cur_val[ACCUM_WIDTH-1], cur_val});
        hit        = (cur_ext <= target_q);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        peak_idx_d = peak_idx_q;
        peak_val_d = peak_val_q;
        target_d   = target_q;
        f1_d       = f1_q;
        f2_d       = f2_q;
        l1_d       = l1_q;
        l2_d       = l2_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFindPeak;
                    idx_d   = '0;
                end
            end
            StFindPeak: begin
                peak_val_d = fin_peak_val;
                peak_idx_d = fin_peak_idx;
                if (idx_q == LastIdx) begin
                    target_d = fin_target;
                    if (fin_peak_idx == '0) begin
                        f1_d    = freq_bin_i[0];
                        f2_d    = freq_bin_i[0];
                        l1_d    = accumulator_val_i[0];
                        l2_d    = accumulator_val_i[0];
                        state_d = StDone;
                    end else begin
                        idx_d   = fin_peak_idx - 1'b1;
                        state_d = StSearch;
                    end
                end else begin
                    idx_d = idx_up;
                end
            end
            StSearch: begin
                if (hit) begin
                    f1_d    = freq_bin_i[idx_q];
                    l1_d    = cur_val;
                    f2_d    = freq_bin_i[idx_up];
                    l2_d    = accumulator_val_i[idx_up];
                    state_d = StDone;
                end else if (idx_q == '0) begin
                    f1_d    = freq_bin_i[0];
                    f2_d    = freq_bin_i[0];
                    l1_d    = accumulator_val_i[0];
                    l2_d    = accumulator_val_i[0];
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            peak_idx_q <= '0;
            peak_val_q <= '0;
            target_q   <= '0;
            f1_q       <= '0;
            f2_q       <= '0;
            l1_q       <= '0;
            l2_q       <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            peak_idx_q <= peak_idx_d;
            peak_val_q <= peak_val_d;
            target_q   <= target_d;
            f1_q       <= f1_d;
            f2_q       <= f2_d;
            l1_q       <= l1_d;
            l2_q       <= l2_d;
        end
    end

    assign f1_o    = f1_q;
    assign f2_o    = f2_q;
    assign L1_o    = l1_q;
    assign L2_o    = l2_q;
    assign valid_o = (state_q == StDone);
    assign busy_o  = (state_q == StFindPeak) || (state_q == StSearch);

endmodule

// File: tb/tb_find_bw_left_edge.sv
// Directed bench for find_bw_left_edge: a reference model fills a scoreboard
// when each search starts; results are popped and checked when valid_o fires.
module tb_find_bw_left_edge;

    localparam int AW = 18;
    localparam int FW = 16;
    localparam int TH = 7680;
    localparam int N  = 24;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic signed [AW-1:0] acc  [N];
    logic signed [FW-1:0] freq [N];
    logic signed [FW-1:0] f1, f2;
    logic signed [AW-1:0] l1, l2;
    logic valid, busy;

    int tests = 0;
    int fails = 0;
    int m_acc  [N];
    int m_freq [N];

    typedef struct {
        int f1;
        int f2;
        int l1;
        int l2;
        int lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    find_bw_left_edge #(
        .ACCUM_WIDTH   (AW),
        .FREQ_BIN_WIDTH(FW),
        .THRESHOLD_DB  (TH),
        .NUM_ACCUMS    (N)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .accumulator_val_i(acc),
        .freq_bin_i       (freq),
        .f1_o             (f1),
        .f2_o             (f2),
        .L1_o             (l1),
        .L2_o             (l2),
        .valid_o          (valid),
        .busy_o           (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_inputs();
        for (int i = 0; i < N; i++) begin
            acc[i]  = AW'(m_acc[i]);
            freq[i] = FW'(m_freq[i]);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        int pk  = 0;
        int hit = -1;
        int tgt;
        for (int i = 1; i < N; i++) if (m_acc[i] > m_acc[pk]) pk = i;
        tgt = m_acc[pk] - TH;
        for (int i = pk - 1; i >= 0; i--) begin
            if (m_acc[i] <= tgt) begin
                hit = i;
                break;
            end
        end
        if (hit < 0) begin
            e.f1 = m_freq[0]; e.f2 = m_freq[0];
            e.l1 = m_acc[0];  e.l2 = m_acc[0];
            e.lat = N + pk + 1;
        end else begin
            e.f1 = m_freq[hit]; e.f2 = m_freq[hit + 1];
            e.l1 = m_acc[hit];  e.l2 = m_acc[hit + 1];
            e.lat = N + (pk - hit) + 1;
        end
        sb.push_back(e);
    endtask

    task automatic run_case(input string tag, input bit restart);
        exp_t e;
        int lat   = 0;
        int extra = 0;
        bit seen  = 1'b0;
        load_inputs();
        push_expected();
        @(negedge clk);
        start = 1'b1;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            start = restart && (lat == 5);
            if (lat == 1) check({tag, " busy_first"}, int'(busy), 1);
            if (valid) seen = 1'b1;
        end
        check({tag, " valid_seen"}, int'(seen), 1);
        if (sb.size() == 0) begin
            check({tag, " scoreboard_nonempty"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            if (seen) begin
                check({tag, " latency"}, lat, e.lat);
                check({tag, " f1"}, int'(f1), e.f1);
                check({tag, " f2"}, int'(f2), e.f2);
                check({tag, " L1"}, int'(l1), e.l1);
                check({tag, " L2"}, int'(l2), e.l2);
                check({tag, " busy_at_valid"}, int'(busy), 0);
                @(negedge clk);
                check({tag, " valid_one_cycle"}, int'(valid), 0);
                check({tag, " hold_f1"}, int'(f1), e.f1);
                check({tag, " hold_L2"}, int'(l2), e.l2);
                repeat (40) begin
                    @(negedge clk);
                    if (valid) extra++;
                end
                check({tag, " no_extra_valid"}, extra, 0);
            end
        end
    endtask

    initial begin
        int extra;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_acc[i]  = 0;
            m_freq[i] = 0;
        end
        load_inputs();
        repeat (3) @(negedge clk);
        check("reset valid", int'(valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset f1", int'(f1), 0);
        check("reset f2", int'(f2), 0);
        check("reset L1", int'(l1), 0);
        check("reset L2", int'(l2), 0);
        rst = 1'b0;

        // Basic edge: hit at 9, bracket 9..10.
        for (int i = 0; i < N; i++) begin
            m_freq[i] = 100 * i;
            m_acc[i]  = -20000;
        end
        m_acc[12] = 0; m_acc[11] = -2560; m_acc[10] = -5120; m_acc[9] = -7680;
        run_case("basic", 1'b0);

        // Never drops far enough: not-found result.
        for (int i = 0; i < N; i++) begin
            m_freq[i] = 100 * i + 250;
            m_acc[i]  = -1000;
        end
        m_acc[5] = 0;
        run_case("notfound", 1'b0);

        // Peak at bin 0 goes straight to not-found.
        for (int i = 0; i < N; i++) begin
            m_freq[i] = -300 + 50 * i;
            m_acc[i]  = -5000 + i;
        end
        m_acc[0] = 100;
        run_case("peak0", 1'b0);

        // Tied maxima at 7 and 15: search must start at 6, not 14.
        for (int i = 0; i < N; i++) begin
            m_freq[i] = 10 * i + 7;
            m_acc[i]  = 0;
        end
        m_acc[7] = 500; m_acc[15] = 500; m_acc[14] = -9000; m_acc[6] = 500 - TH;
        run_case("tie", 1'b0);

        // Peak in the last bin.
        for (int i = 0; i < N; i++) begin
            m_freq[i] = 1000 - 20 * i;
            m_acc[i]  = 0;
        end
        m_acc[N-1] = 1000; m_acc[20] = 1000 - TH;
        run_case("peaklast", 1'b0);

        // Peak near the negative limit: target must not wrap positive.
        for (int i = 0; i < N; i++) begin
            m_freq[i] = 3 * i + 1;
            m_acc[i]  = -131072;
        end
        m_acc[3] = -131000;
        run_case("nowrap", 1'b0);

        // Second start while busy is ignored.
        for (int i = 0; i < N; i++) begin
            m_freq[i] = 100 * i;
            m_acc[i]  = -20000;
        end
        m_acc[12] = 0; m_acc[11] = -2560; m_acc[10] = -5120; m_acc[9] = -7680;
        run_case("restart", 1'b1);

        // Reset during SEARCH aborts the search.
        for (int i = 0; i < N; i++) begin
            m_freq[i] = 100 * i + 250;
            m_acc[i]  = -1000;
        end
        m_acc[5] = 0;
        load_inputs();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 1) @(negedge clk);
        check("midrst busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst valid", int'(valid), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst f1", int'(f1), 0);
        check("midrst f2", int'(f2), 0);
        check("midrst L1", int'(l1), 0);
        check("midrst L2", int'(l2), 0);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) extra++;
        end
        check("midrst no_valid", extra, 0);
        run_case("after_rst", 1'b0);

        // A few random spectra.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                m_freq[i] = int'($urandom_range(0, 60000)) - 30000;
                m_acc[i]  = int'($urandom_range(0, 40000)) - 20000;
            end
            run_case($sformatf("random%0d", r), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/find_bw_left_edge.md
FIND_BW_LEFT_EDGE -- requirements
Module: find_bw_left_edge

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter ACCUM_WIDTH, default 18, SHALL set the width of the signed power samples (dB, Q.8 fixed point).
REQ-003 Parameter FREQ_BIN_WIDTH, default 16, SHALL set the width of the signed frequency-bin values.
REQ-004 Parameter THRESHOLD_DB, default 7680 (30.0 dB in Q8.8), SHALL set the positive drop below peak that defines the edge.
REQ-005 Parameter NUM_ACCUMS, default 24, SHALL set the number of spectrum bins (minimum 2).
REQ-006 clk_i  in  1  SHALL be the clock; all logic is rising-edge.
REQ-007 rst_i  in  1  SHALL be the synchronous active-high reset.
REQ-008 start_i  in  1  SHALL be a single-cycle pulse that starts one search.
REQ-009 accumulator_val_i  in  NUM_ACCUMS x ACCUM_WIDTH signed  SHALL carry the power per bin.
REQ-010 freq_bin_i  in  NUM_ACCUMS x FREQ_BIN_WIDTH signed  SHALL carry the frequency per bin.
REQ-011 f1_o, f2_o  out  FREQ_BIN_WIDTH signed  SHALL give the lower and upper bracketing frequencies.
REQ-012 L1_o, L2_o  out  ACCUM_WIDTH signed  SHALL give the powers at f1_o and f2_o.
REQ-013 valid_o  out  1  SHALL pulse for one cycle when results are final.
REQ-014 busy_o  out  1  SHALL be high while a search is in progress.

Function
REQ-015 FSM states SHALL be IDLE, FIND_PEAK, SEARCH and DONE.
REQ-016 In IDLE, start_i=1 SHALL move to FIND_PEAK with index 0; start_i in any other state SHALL be ignored.
REQ-017 FIND_PEAK SHALL examine one bin per cycle, indices 0..NUM_ACCUMS-1 (NUM_ACCUMS cycles), tracking the maximum with a signed compare; ties SHALL keep the lowest index.
REQ-018 After FIND_PEAK, target SHALL be computed as peak − THRESHOLD_DB at ACCUM_WIDTH+1 bits with no wrap.
REQ-019 If peak index is 0, the FSM SHALL go directly to the not-found result; otherwise it SHALL enter SEARCH at index peak−1.
REQ-020 SEARCH SHALL compare one bin per cycle, moving toward index 0; a hit is accumulator_val_i[i] <= target (signed).
REQ-021 On a hit at i, the block SHALL register f1_o=freq_bin_i[i], L1_o=accumulator_val_i[i], f2_o=freq_bin_i[i+1], L2_o=accumulator_val_i[i+1], then enter DONE.
REQ-022 A miss at index 0 SHALL give the not-found result: f1_o=f2_o=freq_bin_i[0], L1_o=L2_o=accumulator_val_i[0]; then enter DONE.
REQ-023 DONE SHALL assert valid_o for exactly one cycle, then return to IDLE.
REQ-024 busy_o SHALL be high in FIND_PEAK and SEARCH and low in IDLE and DONE.
REQ-025 f1_o, f2_o, L1_o and L2_o SHALL hold their values after DONE until the next result is registered.
REQ-026 Inputs SHALL be sampled live and not latched; the environment SHALL hold them stable from start_i until valid_o.
REQ-027 Latency from the start_i cycle to valid_o SHALL be NUM_ACCUMS + (peak_idx − hit_idx) + 1 cycles; the not-found case counts hit_idx=0.

Reset
REQ-028 Reset SHALL force IDLE; valid_o=0, busy_o=0, and f1_o, f2_o, L1_o, L2_o all 0.
REQ-029 Reset asserted mid-search SHALL abort the search with no valid_o pulse, and the next start_i SHALL behave normally.

Verification
REQ-030 freq[i]=100·i; acc[12]=0, acc[11]=−2560, acc[10]=−5120, acc[9]=−7680, others −20000 -> f1=900, L1=−7680, f2=1000, L2=−5120, valid one cycle.
REQ-031 All acc=−1000 except acc[5]=0 (no bin reaches −7680) -> f1=f2=freq[0], L1=L2=−1000.
REQ-032 Peak at index 0 (acc[0]=100, others lower) -> not-found result with freq[0] and acc[0], latency NUM_ACCUMS+1.
REQ-033 Equal maxima at indices 7 and 15 -> search starts at index 6 (lowest-index peak).
REQ-034 start_i pulsed again while busy_o=1 -> ignored; exactly one valid_o pulse occurs.
REQ-035 rst_i asserted during SEARCH -> no valid_o, outputs 0, busy_o 0; a following start_i gives the correct result.
